// File: rtl/bomb_if.sv
// Placement requests, player positions and rendered bomb state between
// the game logic and the bomb manager.
interface bomb_if;
  logic        place_p1;
  logic [3:0]  p1_x;
  logic [3:0]  p1_y;
  logic        place_p2;
  logic [3:0]  p2_x;
  logic [3:0]  p2_y;
  logic        p1_ready;
  logic        p2_ready;
  logic [99:0] bomb_bit0;
  logic [99:0] bomb_bit1;
  logic [1:0]  game_over;

  modport master (
    output place_p1, p1_x, p1_y, place_p2, p2_x, p2_y,
    input  p1_ready, p2_ready, bomb_bit0, bomb_bit1, game_over
  );
  modport slave (
    input  place_p1, p1_x, p1_y, place_p2, p2_x, p2_y,
    output p1_ready, p2_ready, bomb_bit0, bomb_bit1, game_over
  );
endinterface

// File: rtl/bomb_manager.sv
// Two-player bomb lifecycle: fuse/blast timers per slot, chain reactions,
// registered 10x10 cell-state map and sticky game_over code.
module bomb_slot #(
  parameter int PHASE_CYCLES = 25000000,
  parameter int BLAST_CYCLES = 12500000,
  parameter int TIMER_W      = 25
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic       chain,
  input  logic [3:0] ax,
  input  logic [3:0] ay,
  output logic [1:0] st,
  output logic [3:0] x,
  output logic [3:0] y
);
  // Encodings match the cell codes so the map logic can reuse them.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_NEW = 2'd1, S_AGED = 2'd2, S_EXPL = 2'd3} state_t;
  localparam logic [TIMER_W-1:0] PH_LAST = TIMER_W'(PHASE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BL_LAST = TIMER_W'(BLAST_CYCLES - 1);

  state_t             state;
  logic [TIMER_W-1:0] tmr;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= S_NEW;
          tmr   <= '0;
          x     <= ax;
          y     <= ay;
        end
        S_NEW, S_AGED: begin
          // A chain trigger wins over natural expiry; both land in EXPL at 0.
          if (chain) begin
            state <= S_EXPL;
            tmr   <= '0;
          end else if (tmr == PH_LAST) begin
            state <= (state == S_NEW) ? S_AGED : S_EXPL;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_EXPL: begin
          if (tmr == BL_LAST) begin
            state <= S_IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign st = state;
endmodule

module bomb_manager #(
  parameter int PHASE_CYCLES = 25000000,
  parameter int BLAST_CYCLES = 12500000,
  parameter int TIMER_W      = 25
) (
  input  logic  pixel_clk,
  input  logic  rst_n,
  bomb_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_NEW = 2'd1, ST_AGED = 2'd2, ST_EXPL = 2'd3;

  typedef struct packed {
    logic       place;
    logic [3:0] x;
    logic [3:0] y;
  } place_req_t;

  place_req_t [1:0]      req;
  logic [1:0][1:0]       st;
  logic [1:0][3:0]       sx;
  logic [1:0][3:0]       sy;
  logic [1:0]            acc;
  logic [1:0]            chain;
  logic                  hit_p1;
  logic                  hit_p2;
  logic [99:0]           b0_nxt, b1_nxt, b0_q, b1_q;
  logic [1:0]            go_q;

  // Centre plus orthogonal neighbours, clipped to the 0-9 grid.
  function automatic logic in_foot(input logic [3:0] px, input logic [3:0] py,
                                   input logic [3:0] cx, input logic [3:0] cy);
    logic on_col, on_row;
    on_col = (px == cx) && ((py == cy) || (py == cy + 4'd1) || (cy == py + 4'd1));
    on_row = (py == cy) && ((px == cx + 4'd1) || (cx == px + 4'd1));
    return (px < 4'd10) && (py < 4'd10) && (on_col || on_row);
  endfunction

  assign req[0] = {bus.place_p1, bus.p1_x, bus.p1_y};
  assign req[1] = {bus.place_p2, bus.p2_x, bus.p2_y};

  always_comb begin
    acc[0] = req[0].place && (st[0] == ST_IDLE) && (go_q == 2'd0) &&
             (req[0].x < 4'd10) && (req[0].y < 4'd10) &&
             !((st[1] != ST_IDLE) && (sx[1] == req[0].x) && (sy[1] == req[0].y));
    acc[1] = req[1].place && (st[1] == ST_IDLE) && (go_q == 2'd0) &&
             (req[1].x < 4'd10) && (req[1].y < 4'd10) &&
             !((st[0] != ST_IDLE) && (sx[0] == req[1].x) && (sy[0] == req[1].y)) &&
             !(acc[0] && (req[0].x == req[1].x) && (req[0].y == req[1].y));
  end

  assign chain[0] = (st[1] == ST_EXPL) && in_foot(sx[0], sy[0], sx[1], sy[1]);
  assign chain[1] = (st[0] == ST_EXPL) && in_foot(sx[1], sy[1], sx[0], sy[0]);

  assign hit_p1 = ((st[0] == ST_EXPL) && in_foot(bus.p1_x, bus.p1_y, sx[0], sy[0])) ||
                  ((st[1] == ST_EXPL) && in_foot(bus.p1_x, bus.p1_y, sx[1], sy[1]));
  assign hit_p2 = ((st[0] == ST_EXPL) && in_foot(bus.p2_x, bus.p2_y, sx[0], sy[0])) ||
                  ((st[1] == ST_EXPL) && in_foot(bus.p2_x, bus.p2_y, sx[1], sy[1]));

  for (genvar k = 0; k < 2; k++) begin : g_slot
    bomb_slot #(
      .PHASE_CYCLES(PHASE_CYCLES),
      .BLAST_CYCLES(BLAST_CYCLES),
      .TIMER_W     (TIMER_W)
    ) u_slot (
      .pixel_clk(pixel_clk),
      .rst_n    (rst_n),
      .accept   (acc[k]),
      .chain    (chain[k]),
      .ax       (req[k].x),
      .ay       (req[k].y),
      .st       (st[k]),
      .x        (sx[k]),
      .y        (sy[k])
    );
  end

  for (genvar c = 0; c < 100; c++) begin : g_cell
    localparam logic [3:0] CX = 4'(c % 10);
    localparam logic [3:0] CY = 4'(c / 10);
    logic expl, aged, fresh;
    assign expl  = ((st[0] == ST_EXPL) && in_foot(CX, CY, sx[0], sy[0])) ||
                   ((st[1] == ST_EXPL) && in_foot(CX, CY, sx[1], sy[1]));
    assign aged  = ((st[0] == ST_AGED) && (sx[0] == CX) && (sy[0] == CY)) ||
                   ((st[1] == ST_AGED) && (sx[1] == CX) && (sy[1] == CY));
    assign fresh = ((st[0] == ST_NEW) && (sx[0] == CX) && (sy[0] == CY)) ||
                   ((st[1] == ST_NEW) && (sx[1] == CX) && (sy[1] == CY));
    assign b1_nxt[c] = expl || aged;
    assign b0_nxt[c] = expl || (!aged && fresh);
  end

  // {hit_p1, hit_p2} maps directly onto the winner code: p1 hit -> 2, p2 hit -> 1.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      b0_q <= '0;
      b1_q <= '0;
      go_q <= '0;
    end else begin
      b0_q <= b0_nxt;
      b1_q <= b1_nxt;
      if (go_q == 2'd0) go_q <= {hit_p1, hit_p2};
    end
  end

  assign bus.bomb_bit0 = b0_q;
  assign bus.bomb_bit1 = b1_q;
  assign bus.game_over = go_q;
  assign bus.p1_ready  = (st[0] == ST_IDLE) && (go_q == 2'd0);
  assign bus.p2_ready  = (st[1] == ST_IDLE) && (go_q == 2'd0);
endmodule

// File: tb/tb_bomb_manager.sv
// Scoreboard bench for bomb_manager with short fuse/blast times.
module tb_bomb_manager;
  localparam int PH = 4;
  localparam int BL = 2;

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b0;
  bomb_if bus();

  bomb_manager #(.PHASE_CYCLES(PH), .BLAST_CYCLES(BL), .TIMER_W(3)) dut (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [99:0] b0;
    logic [99:0] b1;
    logic [1:0]  go;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   hist[100][4];

  // Model: a slot is born at cycle born[k] and blasts from blast[k] for BL cycles.
  int         now;
  bit         live[2];
  int         born[2], blast[2], mx[2], my[2];
  logic [1:0] go_m;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sst(int k);
    if (!live[k]) return 0;
    if (now < blast[k]) return (now - born[k] < PH) ? 1 : 2;
    if (now < blast[k] + BL) return 3;
    return 0;
  endfunction

  function automatic bit foot(int px, int py, int cx, int cy);
    int d;
    if (px > 9 || py > 9) return 1'b0;
    d = (px > cx ? px - cx : cx - px) + (py > cy ? py - cy : cy - py);
    return d <= 1;
  endfunction

  task automatic drive(bit pl1, int x1, int y1, bit pl2, int x2, int y2);
    bus.place_p1 = pl1; bus.p1_x = 4'(x1); bus.p1_y = 4'(y1);
    bus.place_p2 = pl2; bus.p2_x = 4'(x2); bus.p2_y = 4'(y2);
  endtask

  task automatic clr_hist();
    for (int c = 0; c < 100; c++)
      for (int v = 0; v < 4; v++) hist[c][v] = 0;
  endtask

  task automatic tick();
    int   s[2], px[2], py[2];
    bit   pl[2], acc[2], h1, h2;
    exp_t e;
    pl[0] = bus.place_p1; px[0] = int'(bus.p1_x); py[0] = int'(bus.p1_y);
    pl[1] = bus.place_p2; px[1] = int'(bus.p2_x); py[1] = int'(bus.p2_y);
    for (int k = 0; k < 2; k++) s[k] = sst(k);
    for (int c = 0; c < 100; c++) begin
      int code, v;
      code = 0;
      for (int k = 0; k < 2; k++) begin
        v = 0;
        if (s[k] == 3 && foot(c % 10, c / 10, mx[k], my[k])) v = 3;
        else if ((s[k] == 1 || s[k] == 2) && mx[k] == c % 10 && my[k] == c / 10) v = s[k];
        if (v > code) code = v;
      end
      e.b0[c] = (code & 1) != 0;
      e.b1[c] = (code & 2) != 0;
    end
    h1 = 0; h2 = 0;
    for (int k = 0; k < 2; k++) begin
      if (s[k] == 3 && foot(px[0], py[0], mx[k], my[k])) h1 = 1;
      if (s[k] == 3 && foot(px[1], py[1], mx[k], my[k])) h2 = 1;
    end
    e.go = (go_m != 2'd0) ? go_m : {h1, h2};
    sb.push_back(e);
    for (int k = 0; k < 2; k++) begin
      int o;
      o = 1 - k;
      if ((s[k] == 1 || s[k] == 2) && s[o] == 3 && foot(mx[k], my[k], mx[o], my[o]) &&
          blast[k] > now + 1)
        blast[k] = now + 1;
    end
    for (int k = 0; k < 2; k++) begin
      int o;
      o = 1 - k;
      acc[k] = pl[k] && s[k] == 0 && go_m == 2'd0 && px[k] < 10 && py[k] < 10 &&
               !(s[o] != 0 && mx[o] == px[k] && my[o] == py[k]);
    end
    if (acc[0] && px[0] == px[1] && py[0] == py[1]) acc[1] = 0;
    for (int k = 0; k < 2; k++)
      if (acc[k]) begin
        live[k] = 1; born[k] = now + 1; blast[k] = now + 1 + 2 * PH;
        mx[k] = px[k]; my[k] = py[k];
      end
    go_m = e.go;
    now++;
    @(posedge pixel_clk);
    #1;
    e = sb.pop_front();
    chk("bomb_bit0", bus.bomb_bit0, e.b0);
    chk("bomb_bit1", bus.bomb_bit1, e.b1);
    chk("game_over", bus.game_over, e.go);
    chk("p1_ready", bus.p1_ready, sst(0) == 0 && go_m == 2'd0);
    chk("p2_ready", bus.p2_ready, sst(1) == 0 && go_m == 2'd0);
    for (int c = 0; c < 100; c++) hist[c][{bus.bomb_bit1[c], bus.bomb_bit0[c]}]++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.place_p1 = 1'($urandom); bus.p1_x = 4'($urandom_range(0, 15)); bus.p1_y = 4'($urandom_range(0, 15));
      bus.place_p2 = 1'($urandom); bus.p2_x = 4'($urandom_range(0, 15)); bus.p2_y = 4'($urandom_range(0, 15));
      #1;
      chk("rst_bit0", bus.bomb_bit0, 100'd0);
      chk("rst_bit1", bus.bomb_bit1, 100'd0);
      chk("rst_game_over", bus.game_over, 2'd0);
      @(posedge pixel_clk);
    end
    #1;
    drive(0, 9, 9, 0, 0, 9);
    rst_n = 1'b1;
    now = 0; live[0] = 0; live[1] = 0; go_m = 2'd0;
    sb.delete();
    #1;
    chk("rst_p1_ready", bus.p1_ready, 1'b1);
    chk("rst_p2_ready", bus.p2_ready, 1'b1);
    clr_hist();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    do_reset();

    // Lifecycle at (3,2); p1 steps away after placing.
    drive(1, 3, 2, 0, 0, 9); tick();
    drive(0, 9, 9, 0, 0, 9); run(14);
    chk("life_23_new", hist[23][1], 4);
    chk("life_23_aged", hist[23][2], 4);
    chk("life_23_expl", hist[23][3], 2);
    chk("life_13_expl", hist[13][3], 2);
    chk("life_33_expl", hist[33][3], 2);
    chk("life_end_map", {bus.bomb_bit1, bus.bomb_bit0}, 200'd0);

    // Edge clipping at both corners of row 0.
    clr_hist();
    drive(1, 0, 0, 0, 5, 9); tick();
    drive(0, 9, 9, 0, 5, 9); run(12);
    chk("clip00_1", hist[1][3], 2);
    chk("clip00_10", hist[10][3], 2);
    chk("clip00_11", hist[11][3], 0);
    clr_hist();
    drive(1, 9, 0, 0, 5, 9); tick();
    drive(0, 0, 9, 0, 5, 9); run(12);
    chk("clip90_8", hist[8][3], 2);
    chk("clip90_19", hist[19][3], 2);
    chk("clip90_10", hist[10][3], 0);

    // Same-cell collision, placement while NEW, out-of-range column.
    clr_hist();
    drive(1, 5, 5, 1, 5, 5); tick();
    drive(1, 2, 2, 1, 10, 3); tick();
    drive(0, 9, 9, 0, 0, 9); run(12);
    chk("coll_55_new", hist[55][1], 4);
    chk("coll_22_empty", hist[22][0], 14);

    // Mid-operation reset drops the live bomb.
    drive(1, 7, 7, 0, 0, 9); tick();
    drive(0, 9, 9, 0, 0, 9); run(5);
    do_reset();

    // Chain: p2 at (4,5) caught by p1's blast at (4,4).
    drive(1, 4, 4, 0, 0, 9); tick();
    drive(0, 0, 0, 0, 0, 9); tick();
    drive(0, 0, 0, 1, 4, 5); tick();
    drive(0, 0, 0, 0, 9, 9); run(12);
    chk("chain_54_expl", hist[54][3], 3);
    chk("chain_64_expl", hist[64][3], 2);
    chk("chain_55_expl", hist[55][3], 2);

    // p2 in the blast: player 1 wins; later placement ignored.
    do_reset();
    drive(1, 3, 2, 0, 3, 3); tick();
    drive(0, 9, 9, 0, 3, 3); run(12);
    chk("go_p1_wins", bus.game_over, 2'd1);
    clr_hist();
    drive(1, 0, 0, 0, 3, 3); tick();
    drive(0, 9, 9, 0, 3, 3); run(3);
    chk("go_place_ignored", hist[0][1], 0);
    chk("go_sticky", bus.game_over, 2'd1);

    // Both players in the blast: draw.
    do_reset();
    drive(1, 3, 2, 0, 3, 3); tick();
    drive(0, 3, 1, 0, 3, 3); run(12);
    chk("go_draw", bus.game_over, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
